// File: rtl/router_pkg.sv
// Shared router constants and helpers, common to the FIFO, FSM and sync blocks.
package router_pkg;

  localparam int unsigned ROUTER_MAX_CH      = 16;
  localparam int unsigned ROUTER_DEF_TIMEOUT = 30;

  // Address width for n channels; a single channel still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel idle timer: pulses soft_reset after TIMEOUT unread cycles with data pending.
module router_sync_timer #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset,
  output logic tmo_evt
);

  logic [CNT_W-1:0] cnt_q;
  logic             soft_q;

  // True on the edge that will raise soft_reset; feeds the sticky status in the top.
  assign tmo_evt    = vld && !rd && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign soft_reset = soft_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      soft_q <= 1'b0;
    end else if (!vld || rd) begin
      cnt_q  <= '0;
      soft_q <= 1'b0;
    end else if (tmo_evt) begin
      cnt_q  <= '0;
      soft_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      soft_q <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_nch.sv
// Router synchroniser for NUM_CH output FIFOs: address latch, write steering,
// full-flag mux, valid-out and per-channel idle timeout with sticky status.
module router_sync_nch
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = ROUTER_DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic              clr_status,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_flag
);

  localparam int unsigned ADDR_W = clog2_min1(NUM_CH);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_err_q;
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] tmo_evt;
  logic              unused_data;

  assign unused_data = ^data_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      addr_err_q <= 1'b0;
    end else if (detect_add) begin
      addr_q     <= data_in[ADDR_W-1:0];
      addr_err_q <= (32'(data_in[ADDR_W-1:0]) >= NUM_CH);
    end else begin
      addr_err_q <= 1'b0;
    end
  end

  // Only addresses below NUM_CH ever match, so an invalid address steers nowhere.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out  = ~empty;
  assign addr_err = addr_err_q;

  // A timeout on the same edge as clr_status keeps its bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      flag_q <= '0;
    end else begin
      flag_q <= (clr_status ? '0 : flag_q) | tmo_evt;
    end
  end

  assign timeout_flag = flag_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock      (clock),
      .reset      (reset),
      .vld        (~empty[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g]),
      .tmo_evt    (tmo_evt[g])
    );
  end

endmodule
